// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   - RV32 funct3 width/sign codes for loads and stores
//   - Read-modify-write FSM state encoding
//   - Default data-memory depth in 32-bit words
package dmem_lsu_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 256;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: selects the addressed byte/half of a memory word and
// sign- or zero-extends it according to funct3. Purely combinational.
//   funct3   - RV32 load width/sign code
//   byte_off - req_addr[1:0]
//   rdata    - raw word from data memory
//   data     - aligned, extended result (0 for an unknown code)
module dmem_load_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (byte_off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // Halfword alignment is checked upstream; only bit 1 matters here.
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        unique case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit for the MEM stage.
//   Loads complete combinationally from mem_rdata. SW writes in one cycle.
//   SB/SH do read-modify-write: one stall cycle (IDLE) to capture the word,
//   then a write of the merged word (MERGE).
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   req_*                 - request from the MEM stage (held stable while stall)
//   stall                 - freeze pipeline
//   load_data             - aligned/extended load result, 0 otherwise
//   misaligned            - alignment error or illegal funct3 on this request
//   access_fault          - word index beyond MEM_WORDS
//   stall_cycles          - free-running count of stalled cycles
//   mem_write/addr/wdata  - data-memory write port, mem_rdata async read
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        access_fault,
    output logic [31:0] stall_cycles,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [31:0] merge_q;
    logic [31:0] stall_cycles_q;

    logic        legal;
    logic        sub_word;
    logic        align_err;
    logic        req_ok;
    logic        write_raw;
    logic [31:0] merged;
    logic [31:0] aligned;

    // Decode legality; funct3[1:0] gives access size for every legal code.
    always_comb begin
        legal    = 1'b0;
        sub_word = 1'b0;
        if (req_we) begin
            unique case (req_funct3)
                F3_SB, F3_SH: begin
                    legal    = 1'b1;
                    sub_word = 1'b1;
                end
                F3_SW:   legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end else begin
            unique case (req_funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
                default:                             legal = 1'b0;
            endcase
        end
        align_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    assign misaligned   = req_valid && (!legal || align_err);
    assign access_fault = req_valid && ({2'b00, req_addr[31:2]} >= MEM_WORDS);
    assign req_ok       = req_valid && !misaligned && !access_fault;

    dmem_load_align u_load_align (
        .funct3   (req_funct3),
        .byte_off (req_addr[1:0]),
        .rdata    (mem_rdata),
        .data     (aligned)
    );

    assign load_data = (req_ok && !req_we) ? aligned : 32'h0;
    assign mem_addr  = {req_addr[31:2], 2'b00};

    // Replace the addressed byte/half of the captured word with store data.
    always_comb begin
        merged = merge_q;
        if (req_funct3[1:0] == 2'b00) begin
            unique case (req_addr[1:0])
                2'd0:    merged[7:0]   = req_wdata[7:0];
                2'd1:    merged[15:8]  = req_wdata[7:0];
                2'd2:    merged[23:16] = req_wdata[7:0];
                default: merged[31:24] = req_wdata[7:0];
            endcase
        end else if (req_addr[1]) begin
            merged[31:16] = req_wdata[15:0];
        end else begin
            merged[15:0] = req_wdata[15:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        write_raw = 1'b0;
        mem_wdata = req_wdata;
        unique case (state_q)
            IDLE: begin
                if (req_ok && req_we) begin
                    if (sub_word) begin
                        stall   = 1'b1;
                        state_d = MERGE;
                    end else begin
                        write_raw = 1'b1;
                    end
                end
            end
            MERGE: begin
                // Request is held stable by the pipeline, so it is not re-checked.
                write_raw = 1'b1;
                mem_wdata = merged;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset masks the strobe so a store pending in MERGE is dropped.
    assign mem_write    = write_raw && rst_n;
    assign stall_cycles = stall_cycles_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            merge_q        <= 32'h0;
            stall_cycles_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == MERGE) begin
                merge_q <= mem_rdata;
            end
            if (stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized self-checking bench for dmem_lsu against a transaction-level
// reference model (word array + arithmetic byte/half selection and merging).
module tb_dmem_lsu;

    localparam int unsigned WORDS = 256;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        misaligned;
    logic        access_fault;
    logic [31:0] stall_cycles;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_lsu #(
        .MEM_WORDS (WORDS)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .access_fault (access_fault),
        .stall_cycles (stall_cycles),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory attached to the DUT, and the model's view of it.
    logic [31:0] tbmem   [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic        load_mem;
    int          wr_cnt;
    logic [29:0] rd_idx;

    assign rd_idx    = mem_addr[31:2];
    assign mem_rdata = (rd_idx < 30'(WORDS)) ? tbmem[rd_idx[7:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < WORDS; i++) tbmem[i] <= ref_mem[i];
        end else if (mem_write && rd_idx < 30'(WORDS)) begin
            tbmem[rd_idx[7:0]] <= mem_wdata;
        end
    end

    initial wr_cnt = 0;
    always @(posedge clk) if (mem_write) wr_cnt <= wr_cnt + 1;

    int          total;
    int          bad;
    logic [31:0] exp_stalls;
    logic [31:0] last_load;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(input bit we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        // bytes accessed: 1, 2 or 4
        if (f3 % 4 == 0) return 1;
        if (f3 % 4 == 1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] v;
        logic [31:0] b;
        logic [31:0] h;
        v = w >> (8 * (a % 4));
        b = v % 256;
        h = v % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return w;
            3'd4:    return b;
            default: return h;
        endcase
    endfunction

    function automatic logic [31:0] m_merge(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        sh   = 8 * (a % 4);
        mask = ((m_size(f3) == 1) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    // One request: drive, check combinational outputs, run it to completion,
    // then check write count, counter and that no further stall follows.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        bit          legal;
        bit          e_mis;
        bit          e_flt;
        bit          ok;
        bit          e_stall;
        int          sz;
        int          w0;
        int          e_wr;
        logic [31:0] idx;
        logic [31:0] word;
        logic [31:0] e_load;
        logic [31:0] e_wdata;

        legal = m_legal(we, f3);
        sz    = m_size(f3);
        e_mis = !legal || (a % sz != 0);
        idx   = a / 4;
        e_flt = idx >= WORDS;
        ok    = !e_mis && !e_flt;
        word  = e_flt ? 32'h0 : ref_mem[idx[7:0]];
        e_load  = (ok && !we) ? m_load(f3, a, word) : 32'h0;
        e_stall = ok && we && sz < 4;
        e_wr    = (ok && we) ? 1 : 0;
        e_wdata = (sz < 4) ? m_merge(f3, a, word, wd) : wd;

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        #1;
        w0 = wr_cnt;
        check("misaligned", {31'h0, misaligned}, {31'h0, e_mis});
        check("access_fault", {31'h0, access_fault}, {31'h0, e_flt});
        check("stall", {31'h0, stall}, {31'h0, e_stall});
        check("load_data", load_data, e_load);
        last_load = load_data;
        if (e_stall) begin
            check("rmw_first_wr", {31'h0, mem_write}, 32'h0);
            @(posedge clk);
            exp_stalls = exp_stalls + 1;
            @(negedge clk);
            #1;
            check("merge_stall", {31'h0, stall}, 32'h0);
            check("merge_wr", {31'h0, mem_write}, 32'h1);
            check("merge_wdata", mem_wdata, e_wdata);
        end else begin
            check("mem_write", {31'h0, mem_write}, e_wr);
            if (e_wr == 1) check("sw_wdata", mem_wdata, e_wdata);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("write_count", wr_cnt - w0, e_wr);
        check("stall_cycles", stall_cycles, exp_stalls);
        check("idle_stall", {31'h0, stall}, 32'h0);
        if (e_wr == 1) ref_mem[idx[7:0]] = e_wdata;
    endtask

    initial begin
        int w0;
        total      = 0;
        bad        = 0;
        exp_stalls = 0;
        last_load  = 0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rst_n      = 1'b0;
        load_mem   = 1'b1;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'hFFFF_FF80;
        ref_mem[1] = 32'h0000_0014;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_write", {31'h0, mem_write}, 32'h0);
        load_mem = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_stall_cycles", stall_cycles, 32'h0);
        check("rst_mem_write_after", {31'h0, mem_write}, 32'h0);

        // Sign/zero extension of a negative byte.
        do_req(1'b0, 3'd0, 32'h0, 32'h0);
        check("lb_neg", last_load, 32'hFFFF_FF80);
        do_req(1'b0, 3'd4, 32'h0, 32'h0);
        check("lbu_pos", last_load, 32'h0000_0080);

        // SB into word1, then read it back.
        do_req(1'b1, 3'd0, 32'h5, 32'h0000_00AB);
        check("sb_stalls", stall_cycles, 32'h1);
        check("sb_word1", tbmem[1], 32'h0000_AB14);

        // Misaligned SH leaves memory alone.
        do_req(1'b1, 3'd1, 32'h3, 32'h0000_1234);
        check("sh_mis_word0", tbmem[0], 32'hFFFF_FF80);

        // SW then LW.
        do_req(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF);
        do_req(1'b0, 3'd2, 32'h8, 32'h0);
        check("lw_after_sw", last_load, 32'hDEAD_BEEF);

        // Out-of-range word.
        do_req(1'b0, 3'd2, 32'h400, 32'h0);
        check("lw_fault_data", last_load, 32'h0);

        // Reset during MERGE drops the store.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd1;
        req_addr   = 32'h6;
        req_wdata  = 32'h0000_5555;
        #1;
        check("rstm_stall", {31'h0, stall}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        w0 = wr_cnt;
        check("rstm_no_write", {31'h0, mem_write}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        #1;
        exp_stalls = 0;
        check("rstm_wr_count", wr_cnt - w0, 0);
        check("rstm_word1", tbmem[1], 32'h0000_AB14);
        check("rstm_stall_cycles", stall_cycles, 32'h0);
        check("rstm_stall", {31'h0, stall}, 32'h0);
        // A fresh SB must stall once again, proving the FSM is back in IDLE.
        do_req(1'b1, 3'd0, 32'h6, 32'h0000_00C3);

        // Random mix.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = $urandom_range(0, WORDS * 4 - 1);
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        for (int i = 0; i < WORDS; i++) check($sformatf("mem[%0d]", i), tbmem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 256, giving the number of 32-bit words in the attached data memory.
REQ-002 The block SHALL have input clk, 1 bit, the single clock, with all state on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit, a synchronous active-low reset.
REQ-004 The block SHALL have input req_valid, 1 bit, indicating that the MEM stage presents a load or store this cycle.
REQ-005 The block SHALL have input req_we, 1 bit: 1 means store, 0 means load.
REQ-006 The block SHALL have input req_funct3, 3 bits, carrying the RV32 width and sign code.
REQ-007 The block SHALL have input req_addr, 32 bits, the byte address from the ALU.
REQ-008 The block SHALL have input req_wdata, 32 bits, the store data from rs2, with bytes taken from its low end.
REQ-009 The block SHALL have output stall, 1 bit, which freezes the pipeline while asserted.
REQ-010 The block SHALL have output load_data, 32 bits, the aligned and extended load result.
REQ-011 The block SHALL have output misaligned, 1 bit, flagging an alignment error or illegal funct3 on the current request.
REQ-012 The block SHALL have output access_fault, 1 bit, flagging a word index req_addr[31:2] greater than or equal to MEM_WORDS.
REQ-013 The block SHALL have output stall_cycles, 32 bits, the performance counter of stall cycles.
REQ-014 The block SHALL have output mem_write, 1 bit, the data-memory write strobe.
REQ-015 The block SHALL have output mem_addr, 32 bits, equal to req_addr with bits [1:0] forced to 00.
REQ-016 The block SHALL have output mem_wdata, 32 bits, the full word written to memory.
REQ-017 The block SHALL have input mem_rdata, 32 bits, the asynchronous word read data from memory.

Function
REQ-018 The block SHALL decode loads as funct3 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; any other load code SHALL be illegal.
REQ-019 The block SHALL decode stores as funct3 000 SB, 001 SH and 010 SW; any other store code SHALL be illegal.
REQ-020 The block SHALL flag a request as misaligned when it is LH, LHU or SH with addr[0]=1, LW or SW with addr[1:0]!=00, or any illegal code.
REQ-021 A request SHALL be suppressed when req_valid=1 and misaligned or access_fault is set: no memory write, load_data=0, stall=0, and the flag asserted combinationally that cycle.
REQ-022 A load SHALL complete in zero cycles: load_data SHALL be computed combinationally from mem_rdata, with the byte or halfword selected by addr[1:0], sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-023 load_data SHALL be 0 when req_valid=0 or the request is a store.
REQ-024 An SW SHALL complete in one cycle, with mem_write=1 and mem_wdata=req_wdata.
REQ-025 SB and SH SHALL perform read-modify-write through a two-state FSM with states IDLE and MERGE.
REQ-026 In IDLE with a valid SB or SH, the block SHALL set stall=1 and mem_write=0, capture mem_rdata into merge_q on the clock edge, and move to MERGE.
REQ-027 In MERGE, the block SHALL set stall=0 and mem_write=1, drive mem_wdata as merge_q with the addressed byte or half replaced from req_wdata, and return to IDLE on the next edge.
REQ-028 req_valid, req_we, req_funct3, req_addr and req_wdata SHALL be held stable by the pipeline while stall=1; the block SHALL NOT re-check them for change.
REQ-029 A sub-word store SHALL cost exactly one stall cycle, with no back-to-back stall from the same request.
REQ-030 stall_cycles SHALL increment by 1 on every edge where stall=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 mem_write SHALL be 0 in every cycle where rst_n=0, whatever the state.

Reset
REQ-032 With rst_n low at an edge, the block SHALL reset state to IDLE, merge_q to 0 and stall_cycles to 0.
REQ-033 After reset, stall=0 and mem_write=0 SHALL hold.
REQ-034 A reset asserted in MERGE SHALL abandon the pending store, with no memory write occurring.

Structure
REQ-035 A shared package SHALL hold the funct3 load/store constants, the FSM state enum {IDLE, MERGE} and the default for MEM_WORDS.
REQ-036 Byte and half extraction and extension for loads SHALL be a sub-module, dmem_load_align, which is purely combinational; the FSM, the merge logic and the counter SHALL remain in dmem_lsu.

Verification
REQ-037 With word0=0xFFFFFF80, an LB at 0x0 SHALL give load_data=0xFFFFFF80, and an LBU at 0x0 SHALL give 0x00000080, each with stall=0.
REQ-038 With word1=0x00000014, an SB of req_wdata=0x000000AB at 0x5 SHALL give stall=1 for one cycle, then a single write making word1=0x0000AB14, with stall_cycles=1.
REQ-039 An SH of 0x1234 at 0x3 SHALL give misaligned=1, stall=0, no write, and memory unchanged.
REQ-040 An SW of 0xDEADBEEF at 0x8 SHALL give a single write in the same cycle with stall=0, after which an LW at 0x8 SHALL return 0xDEADBEEF.
REQ-041 An SH at 0x6 with rst_n pulled low in the MERGE cycle SHALL produce no write, leave word1 unchanged, and return state to IDLE with stall_cycles=0.
REQ-042 With MEM_WORDS=256, an LW at 0x400 SHALL give access_fault=1, load_data=0 and no stall.
